instr_loader: RTL and testbench
===============================

# instr_loader

Debug-unit loader upstream of the instruction-fetch stage. Takes a byte stream from the UART receiver, decodes load/run/step commands, assembles big-endian 32-bit instruction words, and writes them into instruction memory through the fetch stage's write port. After loading, it owns the pipeline enable: continuous run until halt, or single-cycle steps.

## Interface
Parameters:
- NB_DATA, 32, instruction word width
- N_ELEMENTS, 128, instruction memory depth in words
- ADDRWIDTH, $clog2(N_ELEMENTS), write-address width (7 at default)
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates a load

Ports:
- clock_i  in  1  single system clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- rx_data_i  in  8  received UART byte
- rx_done_i  in  1  one-cycle pulse; rx_data_i valid this cycle
- halt_i  in  1  pipeline has retired HALT (level)
- debug_unit_o  out  1  1 = loader owns instruction-memory write port
- en_write_o  out  1  one-cycle memory write strobe
- wr_addr_o  out  ADDRWIDTH  memory write address
- instruction_o  out  NB_DATA  word to write
- enable_o  out  1  pipeline enable
- load_done_o  out  1  a complete program is in memory (sticky)
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, WRITE, RUN, STEP.
- Commands, decoded in IDLE only, on rx_done_i: 8'h4C 'L' -> LOAD; 8'h52 'R' -> RUN if load_done_o = 1; 8'h53 'S' -> STEP if load_done_o = 1. Other bytes, and R/S with load_done_o = 0, are ignored with no state change.
- Entering LOAD clears the word address to 0, clears the byte count, clears load_done_o, and sets debug_unit_o = 1.
- LOAD: each rx_done_i shifts rx_data_i into the word, MSB first (first byte -> [31:24]). On the 4th byte, go to WRITE.
- WRITE (one cycle): en_write_o = 1, instruction_o = assembled word, wr_addr_o = current address. Next state:
  - word == HALT_WORD, or address == N_ELEMENTS-1: go to IDLE and set load_done_o.
  - otherwise: increment the address, clear the byte count, return to LOAD.
- Address never wraps. A full memory terminates the load.
- RUN: debug_unit_o = 0, enable_o = 1. On halt_i = 1, drop enable_o in that same cycle (combinational gating) and go to IDLE.
- STEP: enable_o = 1 for exactly one cycle, then IDLE. debug_unit_o = 0 during STEP.
- IDLE after RUN or STEP keeps debug_unit_o = 0 until the next 'L'.
- instruction_o and wr_addr_o hold their last values outside WRITE. They are only meaningful while en_write_o = 1.

## Timing
- Reset values:
  - state IDLE
  - debug_unit_o = 1
  - en_write_o = 0
  - wr_addr_o = 0
  - instruction_o = 0
  - enable_o = 0
  - load_done_o = 0
  - busy_o = 0
- Reset at any point, including mid-word, mid-RUN, or during WRITE, discards the partial word and returns to these values on the next edge. No write strobe is issued.
- Latency: a 4th byte sampled at edge N gives en_write_o high in cycle N+1 for exactly one cycle.
- The next word's first byte may arrive in cycle N+1 (the WRITE cycle). It is accepted and counted, and the byte count resumes at 1 in LOAD. No byte is ever dropped.
- Command byte at edge N: busy_o and the new state are visible from cycle N+1. enable_o rises in cycle N+1 for R/S.
- A halt_i already high when 'R' is accepted gives one cycle of enable_o = 1, then IDLE.
- rx_done_i during RUN or STEP is ignored.

## Test plan
- Load 3 words 0x20010005, 0x20020003, 0xFFFFFFFF (12 bytes after 'L'):
  - exactly 3 en_write_o pulses at addr 0, 1, 2 with those words
  - load_done_o = 1 after the 3rd pulse
  - state IDLE, debug_unit_o = 1
- Back-to-back bytes (rx_done_i every cycle), 8 bytes after 'L' followed by the halt word:
  - writes at addr 0, 1, 2 with correct words; the byte landing in each WRITE cycle is not lost.
- 'R' after load:
  - enable_o = 1 and debug_unit_o = 0 from the next cycle
  - assert halt_i 10 cycles later: enable_o = 0 the same cycle, IDLE next cycle, load_done_o still 1.
- 'S' twice:
  - two isolated single-cycle enable_o pulses
  - 'R'/'S' before any load: no response, enable_o stays 0.
- Memory fill: 128 non-halt words:
  - 128th write at addr 127, then IDLE with load_done_o = 1
  - further bytes other than valid commands are ignored.
- Reset after 2 bytes of word 1:
  - all outputs return to reset values
  - no en_write_o pulse
  - a fresh 'L' + halt word writes 0xFFFFFFFF at addr 0.

Source files
------------

// File: rtl/instr_loader_if.sv
// Bus bundle between the debug-unit loader and the UART / fetch / pipeline side.
// rx_done_i is a one-cycle valid qualifying rx_data_i; there is no ready, the loader accepts every byte.
interface instr_loader_if #(
    parameter int NB_DATA   = 32,
    parameter int ADDRWIDTH = 7
);
    logic [7:0]           rx_data_i;
    logic                 rx_done_i;
    logic                 halt_i;
    logic                 debug_unit_o;
    logic                 en_write_o;
    logic [ADDRWIDTH-1:0] wr_addr_o;
    logic [NB_DATA-1:0]   instruction_o;
    logic                 enable_o;
    logic                 load_done_o;
    logic                 busy_o;
    logic [2:0]           state;

    modport slave (
        input  rx_data_i, rx_done_i, halt_i,
        output debug_unit_o, en_write_o, wr_addr_o, instruction_o,
               enable_o, load_done_o, busy_o, state
    );

    modport master (
        output rx_data_i, rx_done_i, halt_i,
        input  debug_unit_o, en_write_o, wr_addr_o, instruction_o,
               enable_o, load_done_o, busy_o, state
    );
endinterface

// File: rtl/instr_loader.sv
// Debug-unit loader: decodes L/R/S command bytes, assembles big-endian words into
// instruction memory, then owns the pipeline enable for run or single-step.
module instr_loader #(
    parameter int                 NB_DATA    = 32,
    parameter int                 N_ELEMENTS = 128,
    parameter int                 ADDRWIDTH  = $clog2(N_ELEMENTS),
    parameter logic [NB_DATA-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic            clock_i,
    input  logic            reset_i,
    instr_loader_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        STEP  = 3'd4
    } state_t;

    localparam logic [7:0]           CMD_LOAD  = 8'h4C;
    localparam logic [7:0]           CMD_RUN   = 8'h52;
    localparam logic [7:0]           CMD_STEP  = 8'h53;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(N_ELEMENTS - 1);

    state_t               state_q, state_d;
    logic [1:0]           byte_cnt;
    logic [NB_DATA-1:0]   shift_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [ADDRWIDTH-1:0] wr_addr_q;
    logic [NB_DATA-1:0]   instr_q;
    logic                 debug_q;
    logic                 load_done_q;
    logic                 run_first;
    logic                 en_write;
    logic                 enable;
    logic [NB_DATA-1:0]   shifted;

    assign shifted = {shift_q[NB_DATA-9:0], bus.rx_data_i};

    always_comb begin
        state_d  = state_q;
        en_write = 1'b0;
        enable   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_done_i) begin
                    if (bus.rx_data_i == CMD_LOAD)
                        state_d = LOAD;
                    else if (bus.rx_data_i == CMD_RUN && load_done_q)
                        state_d = RUN;
                    else if (bus.rx_data_i == CMD_STEP && load_done_q)
                        state_d = STEP;
                end
            end
            LOAD: begin
                if (bus.rx_done_i && byte_cnt == 2'd3)
                    state_d = WRITE;
            end
            WRITE: begin
                en_write = !reset_i;
                if (instr_q == HALT_WORD || wr_addr_q == LAST_ADDR)
                    state_d = IDLE;
                else
                    state_d = LOAD;
            end
            RUN: begin
                // A halt still high from an earlier run must not swallow the first enable cycle.
                enable = run_first || !bus.halt_i;
                if (bus.halt_i)
                    state_d = IDLE;
            end
            STEP: begin
                enable  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            byte_cnt    <= 2'd0;
            shift_q     <= '0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            instr_q     <= '0;
            debug_q     <= 1'b1;
            load_done_q <= 1'b0;
            run_first   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_first <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_d == LOAD) begin
                        addr_q      <= '0;
                        byte_cnt    <= 2'd0;
                        load_done_q <= 1'b0;
                        debug_q     <= 1'b1;
                    end else if (state_d == RUN) begin
                        debug_q   <= 1'b0;
                        run_first <= 1'b1;
                    end else if (state_d == STEP) begin
                        debug_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.rx_done_i) begin
                        shift_q  <= shifted;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            instr_q   <= shifted;
                            wr_addr_q <= addr_q;
                        end
                    end
                end
                WRITE: begin
                    if (state_d == IDLE) begin
                        load_done_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        // A byte arriving during the write cycle starts the next word.
                        if (bus.rx_done_i) begin
                            shift_q  <= shifted;
                            byte_cnt <= 2'd1;
                        end else begin
                            byte_cnt <= 2'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.debug_unit_o  = debug_q;
    assign bus.en_write_o    = en_write;
    assign bus.wr_addr_o     = wr_addr_q;
    assign bus.instruction_o = instr_q;
    assign bus.enable_o      = enable;
    assign bus.load_done_o   = load_done_q;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.state         = state_q;
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: command tables, word-load tables with a
// write scoreboard, run/step/halt sequences, memory fill and mid-word reset.
module tb_instr_loader;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_STEP = 3'd4;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;

    instr_loader_if #(.NB_DATA(32), .ADDRWIDTH(7)) bus ();

    instr_loader #(.NB_DATA(32), .N_ELEMENTS(128)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [31:0] word;
        logic [6:0]  addr;
    } wvec_t;

    typedef struct {
        logic [7:0] cmd;
        logic       exp_busy;
        logic       exp_enable;
    } cvec_t;

    logic [38:0] exp_q[$];
    int n_vec    = 0;
    int n_err    = 0;
    int n_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every write strobe must match the oldest expected {addr, word}
    always @(negedge clock_i) begin
        if (bus.en_write_o === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0h word %0h with empty queue",
                         bus.wr_addr_o, bus.instruction_o);
            end else begin
                logic [38:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr_o), 32'(e[38:32]));
                check("wr_word", bus.instruction_o, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data_i = b;
        bus.rx_done_i = 1'b1;
        tick();
        bus.rx_done_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input logic [6:0] addr, input int gap);
        exp_q.push_back({addr, w});
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_debug"},     32'(bus.debug_unit_o),  32'd1);
        check({tag, "_en_write"},  32'(bus.en_write_o),    32'd0);
        check({tag, "_wr_addr"},   32'(bus.wr_addr_o),     32'd0);
        check({tag, "_instr"},     bus.instruction_o,      32'd0);
        check({tag, "_enable"},    32'(bus.enable_o),      32'd0);
        check({tag, "_load_done"}, 32'(bus.load_done_o),   32'd0);
        check({tag, "_busy"},      32'(bus.busy_o),        32'd0);
        check({tag, "_state"},     32'(bus.state),         32'(S_IDLE));
    endtask

    wvec_t load_tab[3];
    wvec_t b2b_tab[3];
    cvec_t pre_tab[4];
    int    w0;

    initial begin
        load_tab[0] = '{32'h2001_0005, 7'd0};
        load_tab[1] = '{32'h2002_0003, 7'd1};
        load_tab[2] = '{32'hFFFF_FFFF, 7'd2};
        b2b_tab[0]  = '{32'h1122_3344, 7'd0};
        b2b_tab[1]  = '{32'hA5A5_5A5A, 7'd1};
        b2b_tab[2]  = '{32'hFFFF_FFFF, 7'd2};
        pre_tab[0]  = '{8'h52, 1'b0, 1'b0};
        pre_tab[1]  = '{8'h53, 1'b0, 1'b0};
        pre_tab[2]  = '{8'h00, 1'b0, 1'b0};
        pre_tab[3]  = '{8'hFF, 1'b0, 1'b0};

        bus.rx_data_i = 8'h00;
        bus.rx_done_i = 1'b0;
        bus.halt_i    = 1'b0;
        reset_i       = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        check_reset_values("reset");

        // R/S and junk before any load: no response
        for (int i = 0; i < 4; i++) begin
            send_byte(pre_tab[i].cmd, 0);
            check("pre_busy",   32'(bus.busy_o),   32'(pre_tab[i].exp_busy));
            check("pre_enable", 32'(bus.enable_o), 32'(pre_tab[i].exp_enable));
        end

        // three-word load with gaps
        w0 = n_writes;
        send_byte(8'h4C, 0);
        check("load_state", 32'(bus.state),        32'(S_LOAD));
        check("load_debug", 32'(bus.debug_unit_o), 32'd1);
        for (int i = 0; i < 3; i++) send_word(load_tab[i].word, load_tab[i].addr, 1);
        tick();
        check("load3_count", 32'(n_writes - w0),    32'd3);
        check("load3_done",  32'(bus.load_done_o),  32'd1);
        check("load3_state", 32'(bus.state),        32'(S_IDLE));
        check("load3_debug", 32'(bus.debug_unit_o), 32'd1);

        // back-to-back bytes, one landing in each write cycle
        w0 = n_writes;
        send_byte(8'h4C, 0);
        check("b2b_load_done_cleared", 32'(bus.load_done_o), 32'd0);
        for (int i = 0; i < 3; i++) send_word(b2b_tab[i].word, b2b_tab[i].addr, 0);
        repeat (2) tick();
        check("b2b_count", 32'(n_writes - w0),   32'd3);
        check("b2b_done",  32'(bus.load_done_o), 32'd1);

        // run, ignore bytes during run, halt after 10 cycles
        send_byte(8'h52, 0);
        check("run_enable", 32'(bus.enable_o),     32'd1);
        check("run_debug",  32'(bus.debug_unit_o), 32'd0);
        check("run_state",  32'(bus.state),        32'(S_RUN));
        send_byte(8'h4C, 0);
        check("run_ignores_rx", 32'(bus.state), 32'(S_RUN));
        repeat (8) tick();
        check("run_enable_late", 32'(bus.enable_o), 32'd1);
        bus.halt_i = 1'b1;
        #1;
        check("halt_gates_enable", 32'(bus.enable_o), 32'd0);
        tick();
        bus.halt_i = 1'b0;
        check("halt_state",     32'(bus.state),        32'(S_IDLE));
        check("halt_load_done", 32'(bus.load_done_o),  32'd1);
        check("halt_debug",     32'(bus.debug_unit_o), 32'd0);

        // two single steps
        for (int i = 0; i < 2; i++) begin
            send_byte(8'h53, 0);
            check("step_enable", 32'(bus.enable_o), 32'd1);
            check("step_state",  32'(bus.state),    32'(S_STEP));
            tick();
            check("step_enable_off", 32'(bus.enable_o), 32'd0);
            check("step_idle",       32'(bus.busy_o),   32'd0);
            tick();
        end

        // halt already high when R is accepted
        bus.halt_i = 1'b1;
        send_byte(8'h52, 0);
        check("prehalt_enable", 32'(bus.enable_o), 32'd1);
        tick();
        check("prehalt_enable_off", 32'(bus.enable_o), 32'd0);
        check("prehalt_state",      32'(bus.state),    32'(S_IDLE));
        bus.halt_i = 1'b0;

        // fill all 128 words with non-halt words
        w0 = n_writes;
        send_byte(8'h4C, 0);
        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            send_word(w, 7'(i), $urandom_range(0, 1));
        end
        repeat (2) tick();
        check("fill_count", 32'(n_writes - w0),   32'd128);
        check("fill_done",  32'(bus.load_done_o), 32'd1);
        check("fill_state", 32'(bus.state),       32'(S_IDLE));
        for (int i = 0; i < 6; i++) begin
            send_byte(8'($urandom_range(0, 8'h4B)), 0);
            check("junk_busy",   32'(bus.busy_o),   32'd0);
            check("junk_enable", 32'(bus.enable_o), 32'd0);
        end

        // reset after two bytes of a word
        w0 = n_writes;
        send_byte(8'h4C, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_reset_values("midreset");
        repeat (3) tick();
        check("midreset_no_write", 32'(n_writes - w0), 32'd0);
        send_byte(8'h4C, 0);
        send_word(32'hFFFF_FFFF, 7'd0, 0);
        repeat (2) tick();
        check("fresh_count", 32'(n_writes - w0),   32'd1);
        check("fresh_done",  32'(bus.load_done_o), 32'd1);

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
